// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and defaults for the Sobel frame scheduler
//
// Purpose: scheduler state encoding, ping-pong buffer status encoding and the
//          default widths/timeout used by sobel_frame_scheduler and sobel_buf_slot.
// Ports:   none (package).
package sobel_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_TIMEOUT    = 65535;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    BUF_FREE = 2'd0,
    BUF_FULL = 2'd1,
    BUF_BUSY = 2'd2
  } buf_status_t;

endpackage

// File: rtl/sobel_buf_slot.sv
// rtl/sobel_buf_slot.sv - one ping-pong buffer slot: status plus latched frame descriptor
//
// Purpose: tracks FREE/FULL/BUSY for one frame buffer and holds the pixel count
//          and run bit captured with the frame.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          i_load        - capture accepted into this slot (only honoured when FREE)
//          i_num, i_run  - descriptor latched on i_load
//          i_claim       - scheduler dispatched this slot (FULL -> BUSY)
//          i_free        - scheduler released this slot (-> FREE)
//          o_status      - current status
//          o_num, o_run  - latched descriptor
module sobel_buf_slot
  import sobel_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_num,
  input  logic                  i_run,
  input  logic                  i_claim,
  input  logic                  i_free,
  output buf_status_t           o_status,
  output logic [ADDR_WIDTH-1:0] o_num,
  output logic                  o_run
);

  buf_status_t           r_status;
  logic [ADDR_WIDTH-1:0] r_num;
  logic                  r_run;

  // Load is gated on FREE here as well, so a stray load can never
  // overwrite a frame that is waiting or being processed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= BUF_FREE;
      r_num    <= '0;
      r_run    <= 1'b0;
    end else if (i_free) begin
      r_status <= BUF_FREE;
    end else if (i_claim) begin
      r_status <= BUF_BUSY;
    end else if (i_load && (r_status == BUF_FREE)) begin
      r_status <= BUF_FULL;
      r_num    <= i_num;
      r_run    <= i_run;
    end
  end

  assign o_status = r_status;
  assign o_num    = r_num;
  assign o_run    = r_run;

endmodule

// File: rtl/sobel_frame_scheduler.sv
// rtl/sobel_frame_scheduler.sv - ping-pong frame scheduler between capture writer and Sobel FSM
//
// Purpose: accepts captured frames into two alternating buffers, dispatches them
//          in FIFO order to the Sobel FSM, waits for completion or timeout and
//          releases the buffer. Counts completed and dropped frames.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          i_cap_done/i_cap_num     - capture finished pulse and its pixel count
//          i_run                    - mode latched with an accepted capture
//          i_fsm_idle/i_fsm_done    - Sobel FSM idle level and done pulse
//          o_cap_sel/o_cap_ready    - capture target buffer and its FREE flag
//          o_proc_sel               - buffer the Sobel FSM reads
//          o_start/o_num/o_run      - dispatch pulse and held frame descriptor
//          o_frame_cnt/o_drop_cnt   - completed (wrapping) / dropped (saturating) counts
//          o_err                    - sticky timeout flag
//          o_state                  - scheduler state
module sobel_frame_scheduler
  import sobel_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cap_done,
  input  logic [ADDR_WIDTH-1:0] i_cap_num,
  input  logic                  i_run,
  input  logic                  i_fsm_idle,
  input  logic                  i_fsm_done,
  output logic                  o_cap_sel,
  output logic                  o_cap_ready,
  output logic                  o_proc_sel,
  output logic                  o_start,
  output logic [ADDR_WIDTH-1:0] o_num,
  output logic                  o_run,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt,
  output logic                  o_err,
  output logic [1:0]            o_state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  sched_state_t          r_state;
  sched_state_t          w_next_state;
  logic                  r_cap_sel;
  logic                  r_proc_sel;
  logic [ADDR_WIDTH-1:0] r_num;
  logic                  r_run;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic                  r_err;
  logic                  r_timed_out;
  logic [TW-1:0]         r_wait_cnt;

  buf_status_t           w_status   [2];
  logic [ADDR_WIDTH-1:0] w_slot_num [2];
  logic                  w_slot_run [2];
  logic [1:0]            w_load;
  logic [1:0]            w_claim;
  logic [1:0]            w_free;

  logic                  w_cap_ready;
  logic                  w_cap_accept;
  logic                  w_drop;
  logic                  w_frame_ready;
  logic                  w_timeout;
  logic                  w_dispatch;
  logic                  w_in_wait;
  logic                  w_release;

  assign w_cap_ready   = (w_status[r_cap_sel] == BUF_FREE);
  assign w_cap_accept  = i_cap_done && w_cap_ready && (i_cap_num != '0);
  assign w_drop        = i_cap_done && !w_cap_accept;
  assign w_frame_ready = (w_status[r_proc_sel] == BUF_FULL) && i_fsm_idle;
  assign w_timeout     = (r_wait_cnt == TW'(TIMEOUT - 1));

  assign w_load  = {w_cap_accept & r_cap_sel,  w_cap_accept & ~r_cap_sel};
  assign w_claim = {w_dispatch   & r_proc_sel, w_dispatch   & ~r_proc_sel};
  assign w_free  = {w_release    & r_proc_sel, w_release    & ~r_proc_sel};

  sobel_buf_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load[0]),
    .i_num    (i_cap_num),
    .i_run    (i_run),
    .i_claim  (w_claim[0]),
    .i_free   (w_free[0]),
    .o_status (w_status[0]),
    .o_num    (w_slot_num[0]),
    .o_run    (w_slot_run[0])
  );

  sobel_buf_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load[1]),
    .i_num    (i_cap_num),
    .i_run    (i_run),
    .i_claim  (w_claim[1]),
    .i_free   (w_free[1]),
    .o_status (w_status[1]),
    .o_num    (w_slot_num[1]),
    .o_run    (w_slot_run[1])
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_frame_ready) w_next_state = ST_DISPATCH;
      ST_DISPATCH: w_next_state = ST_WAIT;
      ST_WAIT:     if (i_fsm_done || w_timeout) w_next_state = ST_RELEASE;
      ST_RELEASE:  w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // FSM: state-decoded outputs
  always_comb begin
    w_dispatch = 1'b0;
    w_in_wait  = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      ST_DISPATCH: w_dispatch = 1'b1;
      ST_WAIT:     w_in_wait  = 1'b1;
      ST_RELEASE:  w_release  = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_sel   <= 1'b0;
      r_proc_sel  <= 1'b0;
      r_num       <= '0;
      r_run       <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err       <= 1'b0;
      r_timed_out <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_cap_accept) begin
        r_cap_sel <= ~r_cap_sel;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end

      // Descriptor is captured on the IDLE->DISPATCH edge so it is already
      // valid alongside o_start and stays put until the next dispatch.
      if ((r_state == ST_IDLE) && w_frame_ready) begin
        r_num <= w_slot_num[r_proc_sel];
        r_run <= w_slot_run[r_proc_sel];
      end

      if (w_dispatch) begin
        r_wait_cnt  <= '0;
        r_timed_out <= 1'b0;
      end else if (w_in_wait) begin
        r_wait_cnt <= r_wait_cnt + TW'(1);
      end

      // A done arriving on the timeout cycle counts as a normal completion.
      if (w_in_wait && w_timeout && !i_fsm_done) begin
        r_err       <= 1'b1;
        r_timed_out <= 1'b1;
      end

      if (w_release) begin
        r_proc_sel <= ~r_proc_sel;
        if (!r_timed_out) begin
          r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_cap_sel   = r_cap_sel;
  assign o_cap_ready = w_cap_ready;
  assign o_proc_sel  = r_proc_sel;
  assign o_start     = w_dispatch;
  assign o_num       = r_num;
  assign o_run       = r_run;
  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// tb/tb_sobel_frame_scheduler.sv - self-checking bench for sobel_frame_scheduler
module tb_sobel_frame_scheduler;

  localparam int AW = 14;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap_done;
  logic [AW-1:0] cap_num;
  logic          run;
  logic          fsm_idle;
  logic          fsm_done;
  logic          o_cap_sel;
  logic          o_cap_ready;
  logic          o_proc_sel;
  logic          o_start;
  logic [AW-1:0] o_num;
  logic          o_run;
  logic [CW-1:0] o_frame_cnt;
  logic [CW-1:0] o_drop_cnt;
  logic          o_err;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sobel_frame_scheduler #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cap_done  (cap_done),
    .i_cap_num   (cap_num),
    .i_run       (run),
    .i_fsm_idle  (fsm_idle),
    .i_fsm_done  (fsm_done),
    .o_cap_sel   (o_cap_sel),
    .o_cap_ready (o_cap_ready),
    .o_proc_sel  (o_proc_sel),
    .o_start     (o_start),
    .o_num       (o_num),
    .o_run       (o_run),
    .o_frame_cnt (o_frame_cnt),
    .o_drop_cnt  (o_drop_cnt),
    .o_err       (o_err),
    .o_state     (o_state)
  );

  typedef struct {
    logic          cap_done;
    logic [AW-1:0] cap_num;
    logic          run;
    logic          idle;
    logic          done;
    logic          e_cap_sel;
    logic          e_ready;
    logic          e_proc_sel;
    logic          e_start;
    logic [AW-1:0] e_num;
    logic          e_run;
    logic [CW-1:0] e_frame;
    logic [CW-1:0] e_drop;
    logic          e_err;
    logic [1:0]    e_state;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cap_done = 1'b0;
    cap_num  = '0;
    run      = 1'b0;
    fsm_idle = 1'b1;
    fsm_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cap(input int num, input logic r);
    cap_done = 1'b1;
    cap_num  = AW'(num);
    run      = r;
    tick();
    cap_done = 1'b0;
    cap_num  = '0;
    run      = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 8 && !o_start; i++) tick();
    check(name, 32'(o_start), 1);
  endtask

  // Called with the DUT in DISPATCH; returns with it back in IDLE.
  task automatic finish_frame();
    fsm_idle = 1'b0;
    tick();
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    fsm_idle = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cap_sel"},  32'(o_cap_sel),   0);
    check({tag, " ready"},    32'(o_cap_ready), 1);
    check({tag, " proc_sel"}, 32'(o_proc_sel),  0);
    check({tag, " start"},    32'(o_start),     0);
    check({tag, " num"},      32'(o_num),       0);
    check({tag, " run"},      32'(o_run),       0);
    check({tag, " frame"},    32'(o_frame_cnt), 0);
    check({tag, " drop"},     32'(o_drop_cnt),  0);
    check({tag, " err"},      32'(o_err),       0);
    check({tag, " state"},    32'(o_state),     0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Single frame, cycle by cycle: inputs during the row, outputs at its start.
    //           cd num   run idle done | csel rdy psel st num   run frm drp err state
    vt[0] = '{1, 9800, 1, 1, 0,   0, 1, 0, 0, 0,    0, 0, 0, 0, 0};
    vt[1] = '{0, 0,    0, 1, 0,   1, 1, 0, 0, 0,    0, 0, 0, 0, 0};
    vt[2] = '{0, 0,    0, 0, 0,   1, 1, 0, 1, 9800, 1, 0, 0, 0, 1};
    vt[3] = '{0, 0,    0, 0, 0,   1, 1, 0, 0, 9800, 1, 0, 0, 0, 2};
    vt[4] = '{0, 0,    0, 0, 1,   1, 1, 0, 0, 9800, 1, 0, 0, 0, 2};
    vt[5] = '{0, 0,    0, 1, 0,   1, 1, 0, 0, 9800, 1, 0, 0, 0, 3};
    vt[6] = '{0, 0,    0, 1, 0,   1, 1, 1, 0, 9800, 1, 1, 0, 0, 0};
    vt[7] = '{0, 0,    0, 1, 0,   1, 1, 1, 0, 9800, 1, 1, 0, 0, 0};

    do_reset();
    check_reset_outputs("reset");

    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d cap_sel", i),  32'(o_cap_sel),   32'(vt[i].e_cap_sel));
      check($sformatf("v%0d ready", i),    32'(o_cap_ready), 32'(vt[i].e_ready));
      check($sformatf("v%0d proc_sel", i), 32'(o_proc_sel),  32'(vt[i].e_proc_sel));
      check($sformatf("v%0d start", i),    32'(o_start),     32'(vt[i].e_start));
      check($sformatf("v%0d num", i),      32'(o_num),       32'(vt[i].e_num));
      check($sformatf("v%0d run", i),      32'(o_run),       32'(vt[i].e_run));
      check($sformatf("v%0d frame", i),    32'(o_frame_cnt), 32'(vt[i].e_frame));
      check($sformatf("v%0d drop", i),     32'(o_drop_cnt),  32'(vt[i].e_drop));
      check($sformatf("v%0d err", i),      32'(o_err),       32'(vt[i].e_err));
      check($sformatf("v%0d state", i),    32'(o_state),     32'(vt[i].e_state));
      cap_done = vt[i].cap_done;
      cap_num  = vt[i].cap_num;
      run      = vt[i].run;
      fsm_idle = vt[i].idle;
      fsm_done = vt[i].done;
      tick();
    end
    cap_done = 1'b0;
    fsm_done = 1'b0;

    // Back-to-back captures while the FSM is busy: the third is dropped.
    do_reset();
    cap(10, 1'b0);
    cap(20, 1'b1);
    check("b2b dispatch start", 32'(o_start), 1);
    check("b2b dispatch num", 32'(o_num), 10);
    check("b2b ready blocked", 32'(o_cap_ready), 0);
    fsm_idle = 1'b0;
    cap(30, 1'b0);
    check("b2b drop", 32'(o_drop_cnt), 1);
    check("b2b cap_sel", 32'(o_cap_sel), 0);
    check("b2b state wait", 32'(o_state), 2);
    tick();
    tick();
    check("b2b ready in wait", 32'(o_cap_ready), 0);
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("b2b state release", 32'(o_state), 3);
    check("b2b ready in release", 32'(o_cap_ready), 0);
    fsm_idle = 1'b1;
    tick();
    check("b2b ready after release", 32'(o_cap_ready), 1);
    check("b2b proc_sel", 32'(o_proc_sel), 1);
    check("b2b frame", 32'(o_frame_cnt), 1);
    tick();
    check("b2b second start", 32'(o_start), 1);
    check("b2b second num", 32'(o_num), 20);
    check("b2b second run", 32'(o_run), 1);
    finish_frame();
    check("b2b frame 2", 32'(o_frame_cnt), 2);
    tick();
    check("b2b no ghost dispatch", 32'(o_state), 0);

    // FIFO ordering through alternation.
    do_reset();
    cap(100, 1'b0);
    cap(200, 1'b1);
    wait_start("ord first start");
    check("ord first num", 32'(o_num), 100);
    check("ord first proc_sel", 32'(o_proc_sel), 0);
    check("ord first run", 32'(o_run), 0);
    finish_frame();
    wait_start("ord second start");
    check("ord second num", 32'(o_num), 200);
    check("ord second proc_sel", 32'(o_proc_sel), 1);
    check("ord second run", 32'(o_run), 1);
    finish_frame();
    check("ord frame", 32'(o_frame_cnt), 2);

    // Timeout: no done, RELEASE after TO WAIT cycles.
    do_reset();
    cap(50, 1'b1);
    wait_start("to start");
    fsm_idle = 1'b0;
    tick();
    n = 0;
    while (o_state == 2'd2 && n < 40) begin
      n++;
      tick();
    end
    check("to wait cycles", 32'(n), TO);
    check("to state release", 32'(o_state), 3);
    check("to err", 32'(o_err), 1);
    fsm_idle = 1'b1;
    tick();
    check("to frame unchanged", 32'(o_frame_cnt), 0);
    check("to err sticky", 32'(o_err), 1);
    check("to state idle", 32'(o_state), 0);

    // Capture accepted in the RELEASE cycle.
    do_reset();
    cap(11, 1'b0);
    wait_start("sim start");
    fsm_idle = 1'b0;
    tick();
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("sim state release", 32'(o_state), 3);
    fsm_idle = 1'b1;
    cap(22, 1'b1);
    check("sim no drop", 32'(o_drop_cnt), 0);
    check("sim cap_sel", 32'(o_cap_sel), 0);
    check("sim proc_sel", 32'(o_proc_sel), 1);
    check("sim frame", 32'(o_frame_cnt), 1);
    wait_start("sim second start");
    check("sim second num", 32'(o_num), 22);
    check("sim second run", 32'(o_run), 1);

    // Reset in WAIT, then stray done and zero-length captures.
    fsm_idle = 1'b0;
    tick();
    check("rw state wait", 32'(o_state), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fsm_idle = 1'b1;
    check_reset_outputs("rw");
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    check("stray done state", 32'(o_state), 0);
    check("stray done frame", 32'(o_frame_cnt), 0);
    cap(0, 1'b1);
    check("zero len drop", 32'(o_drop_cnt), 1);
    check("zero len cap_sel", 32'(o_cap_sel), 0);
    check("zero len ready", 32'(o_cap_ready), 1);
    tick();
    check("zero len no dispatch", 32'(o_state), 0);
    for (int i = 0; i < 20; i++) cap(0, 1'b0);
    check("drop saturates", 32'(o_drop_cnt), 15);

    // Frame counter wraps.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cap(k + 1, 1'b0);
      wait_start($sformatf("wrap start %0d", k));
      finish_frame();
    end
    check("frame wraps", 32'(o_frame_cnt), 1);
    check("wrap no drop", 32'(o_drop_cnt), 0);
    check("wrap no err", 32'(o_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
